// File: rtl/mpeg2_rle_pkg.sv
// Shared types and scan tables for the MPEG2 run-length scan encoder.
package mpeg2_rle_pkg;

    localparam int BLK_COEFS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIND = 2'd1,
        EMIT = 2'd2,
        EOB  = 2'd3
    } state_e;

    // Scan index -> row-major address {row, col}, MPEG2 zigzag scan.
    localparam int ZIGZAG_TAB [BLK_COEFS] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    // Scan index -> row-major address, MPEG2 alternate (vertical) scan.
    localparam int ALT_TAB [BLK_COEFS] = '{
         0,  8, 16, 24,  1,  9,  2, 10, 17, 25, 32, 40, 48, 56, 57, 49,
        41, 33, 26, 18,  3, 11,  4, 12, 19, 27, 34, 42, 50, 58, 35, 43,
        51, 59, 20, 28,  5, 13,  6, 14, 21, 29, 36, 44, 52, 60, 37, 45,
        53, 61, 22, 30,  7, 15, 23, 31, 38, 46, 54, 62, 39, 47, 55, 63
    };

endpackage

// File: rtl/rle_scan_enc_scan_lut.sv
// Scan-order lookup: maps scan index k to the coefficient RAM address.
module scan_lut
    import mpeg2_rle_pkg::*;
(
    input  logic       alt_scan_i,
    input  logic [5:0] k_i,
    output logic [5:0] addr_o
);

    // Pick the table selected for the current block.
    always_comb begin
        addr_o = alt_scan_i ? 6'(ALT_TAB[k_i]) : 6'(ZIGZAG_TAB[k_i]);
    end

endmodule

// File: rtl/rle_scan_enc.sv
// Run-length encoder: scans one 8x8 block, finds the last nonzero, then
// emits (run, level) tokens and a closing EOB over valid/ready.
module rle_scan_enc
    import mpeg2_rle_pkg::*;
#(
    parameter int COEF_W = 12,
    parameter int RUN_W  = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     rdy,
    input  logic                     en,
    input  logic                     intra,
    input  logic                     alt_scan,
    output logic [5:0]               addr,
    input  logic signed [COEF_W-1:0] q,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [RUN_W-1:0]         o_run,
    output logic signed [COEF_W-1:0] o_level,
    output logic                     o_dc,
    output logic                     o_eob
);

    state_e             state_q, state_d;
    logic [6:0]         cnt_q, cnt_d;       // FIND read counter, 0..64
    logic [5:0]         k_q, k_d;           // EMIT: scan index whose data is on q
    logic [RUN_W-1:0]   run_q, run_d;
    logic [5:0]         last_q, last_d;
    logic               any_nz_q, any_nz_d;
    logic               intra_q, intra_d;
    logic               alt_q, alt_d;

    logic [5:0]         lut_k;
    logic [5:0]         find_k;
    logic               q_nz;
    logic               is_dc;
    logic               emit_tok;
    logic               emit_adv;

    scan_lut u_lut (
        .alt_scan_i (alt_q),
        .k_i        (lut_k),
        .addr_o     (addr)
    );

    // q lags addr by one cycle, so during FIND the data belongs to cnt-1.
    assign find_k   = cnt_q[5:0] - 6'd1;
    assign q_nz     = (q != '0);
    assign is_dc    = intra_q && (k_q == 6'd0);
    assign emit_tok = is_dc || q_nz;
    // A zero coefficient never stalls; a token only moves on when accepted.
    assign emit_adv = !emit_tok || o_ready;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            run_q    <= '0;
            last_q   <= '0;
            any_nz_q <= 1'b0;
            intra_q  <= 1'b0;
            alt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            run_q    <= run_d;
            last_q   <= last_d;
            any_nz_q <= any_nz_d;
            intra_q  <= intra_d;
            alt_q    <= alt_d;
        end
    end

    // Next-state, read address and token outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        run_d    = run_q;
        last_d   = last_q;
        any_nz_d = any_nz_q;
        intra_d  = intra_q;
        alt_d    = alt_q;
        lut_k    = 6'd0;
        rdy      = 1'b0;
        o_valid  = 1'b0;
        o_run    = '0;
        o_level  = '0;
        o_dc     = 1'b0;
        o_eob    = 1'b0;

        case (state_q)
            IDLE: begin
                rdy = 1'b1;
                if (en) begin
                    intra_d  = intra;
                    alt_d    = alt_scan;
                    cnt_d    = '0;
                    k_d      = '0;
                    run_d    = '0;
                    last_d   = '0;
                    any_nz_d = 1'b0;
                    state_d  = FIND;
                end
            end

            FIND: begin
                // At cnt=64 the low bits wrap to 0, prefetching k=0 for EMIT.
                lut_k = cnt_q[5:0];
                cnt_d = cnt_q + 7'd1;
                if (cnt_q != 7'd0 && q_nz && !(intra_q && find_k == 6'd0)) begin
                    last_d   = find_k;
                    any_nz_d = 1'b1;
                end
                if (cnt_q == 7'd64) begin
                    k_d     = '0;
                    run_d   = '0;
                    state_d = (any_nz_d || intra_q) ? EMIT : EOB;
                end
            end

            EMIT: begin
                o_valid = emit_tok;
                o_dc    = is_dc;
                o_run   = is_dc ? '0 : run_q;
                o_level = emit_tok ? q : '0;
                // Re-present the pending index while stalled so q holds.
                lut_k   = emit_adv ? k_q + 6'd1 : k_q;
                if (emit_adv) begin
                    k_d   = k_q + 6'd1;
                    run_d = emit_tok ? '0 : run_q + 1'b1;
                    if (k_q == last_q) begin
                        state_d = EOB;
                    end
                end
            end

            EOB: begin
                o_valid = 1'b1;
                o_eob   = 1'b1;
                if (o_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
